// File: rtl/gpio_access_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_access_arbiter
//
// Shares one GPIO output bank between NUM_REQ requesters. Each requester posts
// a masked write (valid/ready). A round-robin FSM grants one write at a time,
// merges it into the output register and then keeps the pins stable for
// HOLD_CYCLES cycles before it samples requests again.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   rst_ni         asynchronous active-low reset
//   req_valid_i    per-requester write request
//   req_ready_o    one-hot grant pulse (registered)
//   req_data_i     write data, requester i uses [i*WIDTH +: WIDTH]
//   req_mask_i     per-bit write enable, same slicing as req_data_i
//   gpio_out_o     registered output bank
//   gpio_update_o  one-cycle pulse in the cycle gpio_out_o takes a new value
//   grant_id_o     index of the last granted requester
//   busy_o         high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module gpio_access_arbiter #(
   parameter int unsigned      NUM_REQ     = 4,
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      HOLD_CYCLES = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
   input  logic [NUM_REQ*WIDTH-1:0]   req_mask_i,
   output logic [WIDTH-1:0]           gpio_out_o,
   output logic                       gpio_update_o,
   output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
   output logic                       busy_o
);

   localparam int unsigned IDW   = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = (HOLD_CYCLES > 32'd1) ? $clog2(HOLD_CYCLES) : 32'd1;
   // Terminal hold count; unused when HOLD_CYCLES is zero because HOLD is skipped.
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((HOLD_CYCLES > 32'd0) ? (HOLD_CYCLES - 32'd1) : 32'd0);
   // Pointer starts at the last requester so requester 0 wins first.
   localparam logic [IDW-1:0]   LAST_RST  = IDW'(NUM_REQ - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDW-1:0]     last_q, last_d;
   logic [IDW-1:0]     grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [WIDTH-1:0]   gpio_q, gpio_d;
   logic               gpio_update_q, gpio_update_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               busy_q, busy_d;

   logic [IDW-1:0]     winner_s;
   logic               winner_vld_s;
   logic [WIDTH-1:0]   sel_data_s;
   logic [WIDTH-1:0]   sel_mask_s;
   logic               sel_valid_s;

   // Round-robin search starting just after last_q. The loop runs from the
   // lowest priority offset to the highest so the highest priority hit is
   // the one written last.
   always_comb begin
      logic [IDW-1:0] cand_s;
      cand_s   = '0;
      winner_s = '0;
      for (int i = int'(NUM_REQ); i >= 32'sd1; i--) begin
         cand_s   = IDW'((int'(last_q) + i) % int'(NUM_REQ));
         winner_s = req_valid_i[cand_s] ? cand_s : winner_s;
      end
      winner_vld_s = |req_valid_i;
   end

   // Select the data, mask and valid of the requester currently granted.
   always_comb begin
      sel_data_s = '0;
      sel_mask_s = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         sel_data_s = (grant_id_q == IDW'(i)) ? req_data_i[i*WIDTH +: WIDTH] : sel_data_s;
         sel_mask_s = (grant_id_q == IDW'(i)) ? req_mask_i[i*WIDTH +: WIDTH] : sel_mask_s;
      end
      sel_valid_s = req_valid_i[grant_id_q];
   end

   // Next-state and next-output logic of the grant FSM.
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      grant_id_d    = grant_id_q;
      req_ready_d   = '0;
      gpio_d        = gpio_q;
      gpio_update_d = 1'b0;
      hold_cnt_d    = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (winner_vld_s) begin
               state_d     = ST_GRANT;
               last_d      = winner_s;
               grant_id_d  = winner_s;
               req_ready_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // A requester that dropped valid during its grant loses the slot;
            // the pointer has already moved past it.
            if (sel_valid_s) begin
               gpio_d        = (gpio_q & ~sel_mask_s) | (sel_data_s & sel_mask_s);
               gpio_update_d = 1'b1;
               hold_cnt_d    = '0;
               if (HOLD_CYCLES == 32'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = ST_IDLE;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset returns every output to its idle value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         last_q        <= LAST_RST;
         grant_id_q    <= '0;
         req_ready_q   <= '0;
         gpio_q        <= RESET_VAL;
         gpio_update_q <= 1'b0;
         hold_cnt_q    <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         grant_id_q    <= grant_id_d;
         req_ready_q   <= req_ready_d;
         gpio_q        <= gpio_d;
         gpio_update_q <= gpio_update_d;
         hold_cnt_q    <= hold_cnt_d;
         busy_q        <= busy_d;
      end
   end

   assign req_ready_o   = req_ready_q;
   assign gpio_out_o    = gpio_q;
   assign gpio_update_o = gpio_update_q;
   assign grant_id_o    = grant_id_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for gpio_access_arbiter. Two instances share clock and reset:
//   dut_a : HOLD_CYCLES=2, RESET_VAL=0
//   dut_b : HOLD_CYCLES=0, RESET_VAL=32'h1234_5678
// A timeline model (when may the arbiter next sample, who is next in the
// rotation, what the bank holds) predicts every registered output and is
// compared on every falling edge. Directed sequences add literal checks.
// -----------------------------------------------------------------------------
module tb_gpio_access_arbiter;

   localparam int NR = 4;
   localparam int W  = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NR-1:0]         valid [2];
   logic [NR-1:0][W-1:0]  data  [2];
   logic [NR-1:0][W-1:0]  mask  [2];
   logic [NR-1:0]         ready [2];
   logic [W-1:0]          gout  [2];
   logic                  upd   [2];
   logic [1:0]            gid   [2];
   logic                  busy  [2];

   gpio_access_arbiter #(.NUM_REQ(NR), .WIDTH(W), .HOLD_CYCLES(2), .RESET_VAL(32'h0000_0000)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
      .req_data_i(data[0]), .req_mask_i(mask[0]), .gpio_out_o(gout[0]),
      .gpio_update_o(upd[0]), .grant_id_o(gid[0]), .busy_o(busy[0]));

   gpio_access_arbiter #(.NUM_REQ(NR), .WIDTH(W), .HOLD_CYCLES(0), .RESET_VAL(32'h1234_5678)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
      .req_data_i(data[1]), .req_mask_i(mask[1]), .gpio_out_o(gout[1]),
      .gpio_update_o(upd[1]), .grant_id_o(gid[1]), .busy_o(busy[1]));

   int     checks = 0;
   int     errors = 0;
   longint cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int hold_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic [W-1:0] rv_of(input int d);
      return (d == 0) ? 32'h0000_0000 : 32'h1234_5678;
   endfunction

   function automatic int oh_idx(input logic [NR-1:0] v);
      for (int j = 0; j < NR; j++) if (v[j]) return j;
      return -1;
   endfunction

   task automatic chk(input string nm, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", nm, d, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0]  m_gpio  [2];
   int            m_last  [2];
   int            m_gid   [2];
   int            m_g     [2];   // requester holding ready this cycle, -1 if none
   longint        free_at [2];   // first cycle in which requests are sampled again
   logic [NR-1:0] e_ready [2];
   logic          e_upd   [2];
   logic          e_busy  [2];

   task automatic model_reset(input int d);
      m_gpio[d]  = rv_of(d);
      m_last[d]  = NR - 1;
      m_gid[d]   = 0;
      m_g[d]     = -1;
      free_at[d] = 0;
      e_ready[d] = '0;
      e_upd[d]   = 1'b0;
      e_busy[d]  = 1'b0;
   endtask

   // Uses the inputs of cycle cyc to predict the outputs of cycle cyc+1.
   task automatic model_step(input int d);
      logic [NR-1:0] nr;
      logic          nu;
      int            g;
      int            c;
      logic [W-1:0]  dt;
      logic [W-1:0]  mk;
      nr = '0;
      nu = 1'b0;
      if (m_g[d] >= 0) begin
         g  = m_g[d];
         dt = data[d][g];
         mk = mask[d][g];
         if (valid[d][g]) begin
            m_gpio[d]  = (m_gpio[d] & ~mk) | (dt & mk);
            nu         = 1'b1;
            free_at[d] = cyc + 1 + hold_of(d);
         end else begin
            free_at[d] = cyc + 1;
         end
         m_g[d] = -1;
      end else if (cyc >= free_at[d] && valid[d] != '0) begin
         g = -1;
         for (int j = 1; j <= NR; j++) begin
            c = (m_last[d] + j) % NR;
            if (g < 0 && valid[d][c]) g = c;
         end
         nr[g]      = 1'b1;
         m_gid[d]   = g;
         m_last[d]  = g;
         m_g[d]     = g;
         free_at[d] = cyc + 1000000;
      end
      e_ready[d] = nr;
      e_upd[d]   = nu;
      e_busy[d]  = (cyc + 1 < free_at[d]);
   endtask

   // Compare process: every falling edge, both instances.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            chk("rst_gpio",  d, gout[d], rv_of(d));
            chk("rst_ready", d, W'(ready[d]), 32'h0);
            chk("rst_upd",   d, W'(upd[d]), 32'h0);
            chk("rst_busy",  d, W'(busy[d]), 32'h0);
            chk("rst_gid",   d, W'(gid[d]), 32'h0);
            model_reset(d);
         end else begin
            chk("gpio",  d, gout[d], m_gpio[d]);
            chk("ready", d, W'(ready[d]), W'(e_ready[d]));
            chk("upd",   d, W'(upd[d]), W'(e_upd[d]));
            chk("busy",  d, W'(busy[d]), W'(e_busy[d]));
            chk("gid",   d, W'(gid[d]), W'(m_gid[d]));
            model_step(d);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [NR-1:0] prev_rdy [2];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_req(input int d);
      for (int i = 0; i < NR; i++) begin
         if (valid[d][i] && prev_rdy[d][i]) begin
            valid[d][i] = 1'b0;
         end else if (valid[d][i] && ready[d][i] && $urandom_range(0, 5) == 0) begin
            valid[d][i] = 1'b0;
         end
         if (!valid[d][i] && !ready[d][i] && $urandom_range(0, 2) == 0) begin
            data[d][i] = $urandom();
            case ($urandom_range(0, 3))
               0:       mask[d][i] = 32'h0000_0000;
               1:       mask[d][i] = 32'hFFFF_FFFF;
               default: mask[d][i] = $urandom();
            endcase
            valid[d][i] = 1'b1;
         end
      end
      prev_rdy[d] = ready[d];
   endtask

   // Handshake on dut_a, literal checks of ready at N+1 and the bank at N+2.
   task automatic single_write(input string nm, input int r, input logic [W-1:0] dt,
                               input logic [W-1:0] mk, input logic [W-1:0] expv);
      logic [NR-1:0] oh;
      oh         = '0;
      oh[r]      = 1'b1;
      valid[0][r] = 1'b1;
      data[0][r]  = dt;
      mask[0][r]  = mk;
      step();
      chk({nm, "_ready"}, 0, W'(ready[0]), W'(oh));
      step();
      valid[0][r] = 1'b0;
      chk({nm, "_gpio"}, 0, gout[0], expv);
      chk({nm, "_upd"},  0, W'(upd[0]), 32'h1);
      step();
      step();
   endtask

   int     ids [$];
   longint at  [$];
   longint ups [$];

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         valid[d]    = '0;
         data[d]     = '0;
         mask[d]     = '0;
         prev_rdy[d] = '0;
      end
      step(); step();
      #1 rst_n = 1'b1;

      // Single write, mask=0 write, and a merge on an all-ones bank.
      single_write("wr_a5", 1, 32'hA5A5_0000, 32'hFFFF_0000, 32'hA5A5_0000);
      single_write("mask0", 2, 32'h1234_5678, 32'h0000_0000, 32'hA5A5_0000);
      single_write("ones",  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      single_write("merge", 3, 32'h0000_0000, 32'h0000_00F0, 32'hFFFF_FF0F);

      // Fairness with all four valid: grants 0,1,2,3,0 four cycles apart.
      valid[0] = 4'hF;
      repeat (20) begin
         step();
         if (ready[0] != '0) begin
            ids.push_back(oh_idx(ready[0]));
            at.push_back(cyc);
         end
      end
      valid[0] = 4'h0;
      chk("fair_count", 0, W'(ids.size()), 32'd5);
      for (int i = 0; i < ids.size(); i++) begin
         chk("fair_order", 0, W'(ids[i]), W'(i % NR));
         if (i > 0) chk("fair_space", 0, W'(at[i] - at[i-1]), 32'd4);
      end
      step(); step();

      // Withdraw: requester 2 drops valid during its grant, requester 3 follows.
      data[0][2] = 32'h0000_0000;
      mask[0][2] = 32'hFFFF_FFFF;
      data[0][3] = 32'h0000_00A0;
      mask[0][3] = 32'h0000_00F0;
      valid[0]   = 4'b1100;
      step();
      chk("wd_ready2", 0, W'(ready[0]), 32'h4);
      valid[0][2] = 1'b0;
      step();
      chk("wd_noupd", 0, W'(upd[0]), 32'h0);
      chk("wd_idle",  0, W'(busy[0]), 32'h0);
      step();
      chk("wd_ready3", 0, W'(ready[0]), 32'h8);
      step();
      valid[0][3] = 1'b0;
      chk("wd_gpio", 0, gout[0], 32'hFFFF_FFAF);
      chk("wd_upd",  0, W'(upd[0]), 32'h1);
      step(); step(); step();

      // Zero hold on dut_b: alternating grants every two cycles, one-hot ready.
      ids.delete();
      at.delete();
      data[1][0] = 32'h0000_FFFF;
      mask[1][0] = 32'h00FF_00FF;
      data[1][1] = 32'hFFFF_0000;
      mask[1][1] = 32'hFFFF_FFFF;
      valid[1]   = 4'b0011;
      repeat (12) begin
         step();
         chk("h0_onehot", 1, W'($countones(ready[1]) <= 1), 32'h1);
         if (ready[1] != '0) begin
            ids.push_back(oh_idx(ready[1]));
            at.push_back(cyc);
         end
         if (upd[1]) ups.push_back(cyc);
      end
      valid[1] = 4'b0000;
      chk("h0_grants",  1, W'(ids.size()), 32'd6);
      chk("h0_updates", 1, W'(ups.size()), 32'd6);
      for (int i = 0; i < ids.size(); i++) begin
         chk("h0_order", 1, W'(ids[i]), W'(i % 2));
         if (i > 0) chk("h0_space", 1, W'(at[i] - at[i-1]), 32'd2);
      end
      for (int i = 1; i < ups.size(); i++) chk("h0_upd_space", 1, W'(ups[i] - ups[i-1]), 32'd2);
      step(); step();

      // Reset asserted in the middle of a hold period.
      valid[0][0] = 1'b1;
      data[0][0]  = 32'hDEAD_BEEF;
      mask[0][0]  = 32'hFFFF_FFFF;
      step();
      step();
      valid[0][0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_gpio",  0, gout[0], 32'h0000_0000);
      chk("rst_mid_ready", 0, W'(ready[0]), 32'h0);
      chk("rst_mid_busy",  0, W'(busy[0]), 32'h0);
      chk("rst_mid_gpio_b", 1, gout[1], 32'h1234_5678);
      step(); step();
      #1 rst_n = 1'b1;

      // Randomized traffic on both instances.
      prev_rdy[0] = '0;
      prev_rdy[1] = '0;
      repeat (3000) begin
         step();
         rand_req(0);
         rand_req(1);
      end
      valid[0] = '0;
      valid[1] = '0;
      repeat (8) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
